// File: rtl/life_scan.sv
// Raster scanner for a Life grid: walks every cell (x,y) once per generation,
// either continuously (run) or for a single generation (step).
module life_scan #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   step,
  output logic                   busy,
  output logic                   valid,
  output logic [LOG2X-1:0]       x,
  output logic [LOG2Y-1:0]       y,
  output logic [LOG2X+LOG2Y-1:0] addr,
  output logic                   first,
  output logic                   last,
  output logic                   gen_done,
  output logic [GEN_W-1:0]       gen
);

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [LOG2X-1:0] X_MAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_MAX = LOG2Y'(Y - 1);

  state_e           state_q, state_d;
  logic [LOG2X-1:0] x_q, x_d;
  logic [LOG2Y-1:0] y_q, y_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             gen_done_q, gen_done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      gen_q      <= '0;
      gen_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      gen_q      <= gen_d;
      gen_done_q <= gen_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    gen_d      = gen_q;
    gen_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (run || step) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        if (x_q == X_MAX) begin
          x_d = '0;
          if (y_q == Y_MAX) begin
            // End of generation: run decides between wrap-around and idle.
            y_d        = '0;
            gen_done_d = 1'b1;
            gen_d      = gen_q + 1'b1;
            if (!run) state_d = IDLE;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid    = (state_q == SCAN);
  assign busy     = valid;
  assign x        = x_q;
  assign y        = y_q;
  assign addr     = {y_q, x_q};
  assign first    = valid && (x_q == '0) && (y_q == '0);
  assign last     = valid && (x_q == X_MAX) && (y_q == Y_MAX);
  assign gen_done = gen_done_q;
  assign gen      = gen_q;

endmodule
